// File: rtl/out_req_pkt_arbiter.sv
// Packet arbiter for the OUT_req upload path: strict-priority source plus
// round-robin among the rest, grant held until tail, overrun watchdog.
module out_req_pkt_arbiter #(
  parameter int unsigned NUM_SRC   = 3,
  parameter int unsigned HP_SRC    = 0,
  parameter int unsigned MAX_FLITS = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   out_rdy,
  input  logic [NUM_SRC-1:0]     v_req,
  input  logic [2*NUM_SRC-1:0]   req_ctrl,
  output logic                   ack_out,
  output logic [NUM_SRC-1:0]     ack_req,
  output logic [NUM_SRC-1:0]     select,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic                   err_overrun
);

  localparam int unsigned CNT_W = (MAX_FLITS == 0) ? 8 : $clog2(MAX_FLITS + 1);
  localparam logic [IDX_W-1:0] HP_IDX = IDX_W'(HP_SRC);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_nxt;
  logic [CNT_W-1:0] r_flit_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_err, w_err_nxt;

  logic             w_hp_hit, w_rr_hit, w_win_vld;
  logic [IDX_W-1:0] w_rr_idx, w_win_idx, w_sel;
  logic [1:0]       w_ctrl;
  logic             w_tail;

  // Winner search: HP source first, then round-robin scan from r_rr_ptr skipping HP.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    w_hp_hit = 1'b0;
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (i == HP_SRC && v_req[IDX_W'(i)]) w_hp_hit = 1'b1;
    end
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_SRC;
      if (!w_rr_hit && v_req[IDX_W'(idx)] && idx != HP_SRC) begin
        w_rr_hit = 1'b1;
        w_rr_idx = IDX_W'(idx);
      end
    end
  end

  assign w_win_vld = w_hp_hit | w_rr_hit;
  assign w_win_idx = w_hp_hit ? HP_IDX : w_rr_idx;
  assign w_sel     = (r_state == S_IDLE) ? w_win_idx : r_owner;

  always_comb begin
    w_ctrl = 2'b00;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (IDX_W'(i) == w_sel) w_ctrl = req_ctrl[2*i +: 2];
    end
  end

  assign w_tail    = (w_ctrl == 2'b11);
  assign w_cnt_inc = (r_flit_cnt == '1) ? r_flit_cnt : r_flit_cnt + CNT_W'(1);

  always_comb begin
    ack_out     = 1'b0;
    ack_req     = '0;
    grant_idx   = '0;
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_flit_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (out_rdy && w_win_vld) begin
          ack_out            = 1'b1;
          ack_req[w_win_idx] = 1'b1;
          grant_idx          = w_win_idx;
          if (!w_hp_hit) begin
            w_rr_nxt = (int'(w_win_idx) == NUM_SRC - 1) ? '0 : w_win_idx + IDX_W'(1);
          end
          if (!w_tail) begin
            w_state_nxt = S_LOCKED;
            w_owner_nxt = w_win_idx;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      S_LOCKED: begin
        grant_idx = r_owner;
        if (out_rdy && v_req[r_owner]) begin
          ack_out          = 1'b1;
          ack_req[r_owner] = 1'b1;
          w_cnt_nxt        = w_cnt_inc;
          if (w_tail) begin
            w_state_nxt = S_IDLE;
          end else if (MAX_FLITS != 0 && w_cnt_inc == CNT_W'(MAX_FLITS)) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) begin
      ack_out   = 1'b0;
      ack_req   = '0;
      grant_idx = '0;
    end
  end

  assign select      = ack_req;
  assign busy        = (r_state == S_LOCKED);
  assign err_overrun = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_flit_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_flit_cnt <= w_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_out_req_pkt_arbiter.sv
// Directed bench: cycle vector table on a 3-source/HP=0/MAX_FLITS=4 arbiter,
// plus a round-robin fairness sequence on a 4-source arbiter without HP.
module tb_out_req_pkt_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rdy_a;
  logic [2:0] v_a, ar_a, sel_a;
  logic [5:0] c_a;
  logic       ao_a, bz_a, er_a;
  logic [1:0] gi_a;

  out_req_pkt_arbiter #(.NUM_SRC(3), .HP_SRC(0), .MAX_FLITS(4)) dut_a (
    .clk(clk), .rst(rst_a), .out_rdy(rdy_a), .v_req(v_a), .req_ctrl(c_a),
    .ack_out(ao_a), .ack_req(ar_a), .select(sel_a), .grant_idx(gi_a),
    .busy(bz_a), .err_overrun(er_a)
  );

  logic       rst_b, rdy_b;
  logic [3:0] v_b, ar_b, sel_b;
  logic [7:0] c_b;
  logic       ao_b, bz_b, er_b;
  logic [1:0] gi_b;

  out_req_pkt_arbiter #(.NUM_SRC(4), .HP_SRC(4), .MAX_FLITS(16)) dut_b (
    .clk(clk), .rst(rst_b), .out_rdy(rdy_b), .v_req(v_b), .req_ctrl(c_b),
    .ack_out(ao_b), .ack_req(ar_b), .select(sel_b), .grant_idx(gi_b),
    .busy(bz_b), .err_overrun(er_b)
  );

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [2:0] v;
    logic [5:0] c;
    logic       ao;
    logic [2:0] ar;
    logic [1:0] gi;
    logic       bz;
    logic       er;
    logic       chk_reg;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t V(logic r, logic rdy, logic [2:0] v, logic [5:0] c,
                             logic ao, logic [2:0] ar, logic [1:0] gi,
                             logic bz, logic er, logic cr);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.v = v; t.c = c; t.ao = ao; t.ar = ar;
    t.gi = gi; t.bz = bz; t.er = er; t.chk_reg = cr;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  // ctrl: src2 [5:4], src1 [3:2], src0 [1:0]; 2'b11 = tail
  initial begin
    rst_a = 1'b1; rdy_a = 1'b0; v_a = '0; c_a = '0;
    rst_b = 1'b1; rdy_b = 1'b0; v_b = '0; c_b = '0;

    //               rst rdy v       c          ao ar      gi    bz er cr
    tv.push_back(V(1, 1, 3'b111, 6'b000000, 0, 3'b000, 2'd0, 0, 0, 1)); // 0 reset
    tv.push_back(V(1, 0, 3'b000, 6'b000000, 0, 3'b000, 2'd0, 0, 0, 1)); // 1
    tv.push_back(V(0, 1, 3'b100, 6'b000000, 1, 3'b100, 2'd2, 0, 0, 1)); // 2 head src2
    tv.push_back(V(0, 1, 3'b100, 6'b000000, 1, 3'b100, 2'd2, 1, 0, 1)); // 3 flit 2
    tv.push_back(V(1, 1, 3'b111, 6'b000000, 0, 3'b000, 2'd0, 0, 0, 0)); // 4 reset mid-packet
    tv.push_back(V(0, 1, 3'b110, 6'b000000, 1, 3'b010, 2'd1, 0, 0, 1)); // 5 post-reset -> src1
    tv.push_back(V(0, 1, 3'b011, 6'b000000, 1, 3'b010, 2'd1, 1, 0, 1)); // 6 HP rises, ignored
    tv.push_back(V(0, 1, 3'b011, 6'b000000, 1, 3'b010, 2'd1, 1, 0, 1)); // 7
    tv.push_back(V(0, 1, 3'b011, 6'b001100, 1, 3'b010, 2'd1, 1, 0, 1)); // 8 tail at flit 4
    tv.push_back(V(0, 1, 3'b011, 6'b000000, 1, 3'b001, 2'd0, 0, 0, 1)); // 9 HP granted, no err
    tv.push_back(V(0, 1, 3'b001, 6'b000011, 1, 3'b001, 2'd0, 1, 0, 1)); // 10 HP tail
    tv.push_back(V(0, 1, 3'b100, 6'b110000, 1, 3'b100, 2'd2, 0, 0, 1)); // 11 single flit
    tv.push_back(V(0, 1, 3'b000, 6'b000000, 0, 3'b000, 2'd0, 0, 0, 1)); // 12 still idle
    tv.push_back(V(0, 1, 3'b100, 6'b000000, 1, 3'b100, 2'd2, 0, 0, 1)); // 13 head src2
    tv.push_back(V(0, 1, 3'b000, 6'b000000, 0, 3'b000, 2'd2, 1, 0, 1)); // 14 bubble
    tv.push_back(V(0, 1, 3'b010, 6'b000000, 0, 3'b000, 2'd2, 1, 0, 1)); // 15 bubble, other req
    tv.push_back(V(0, 1, 3'b100, 6'b000000, 1, 3'b100, 2'd2, 1, 0, 1)); // 16 flit 2
    for (int i = 0; i < 5; i++)
      tv.push_back(V(0, 0, 3'b111, 6'b000000, 0, 3'b000, 2'd2, 1, 0, 1)); // 17-21 backpressure
    tv.push_back(V(0, 1, 3'b100, 6'b110000, 1, 3'b100, 2'd2, 1, 0, 1)); // 22 tail flit 3
    tv.push_back(V(0, 1, 3'b000, 6'b000000, 0, 3'b000, 2'd0, 0, 0, 1)); // 23
    tv.push_back(V(0, 1, 3'b010, 6'b000000, 1, 3'b010, 2'd1, 0, 0, 1)); // 24 watchdog pkt
    tv.push_back(V(0, 1, 3'b010, 6'b000000, 1, 3'b010, 2'd1, 1, 0, 1)); // 25
    tv.push_back(V(0, 1, 3'b010, 6'b000000, 1, 3'b010, 2'd1, 1, 0, 1)); // 26
    tv.push_back(V(0, 1, 3'b010, 6'b000000, 1, 3'b010, 2'd1, 1, 0, 1)); // 27 4th flit cut
    tv.push_back(V(0, 0, 3'b010, 6'b000000, 0, 3'b000, 2'd0, 0, 1, 1)); // 28 err pulse
    tv.push_back(V(0, 1, 3'b000, 6'b000000, 0, 3'b000, 2'd0, 0, 0, 1)); // 29 err gone
    tv.push_back(V(0, 1, 3'b110, 6'b111100, 1, 3'b100, 2'd2, 0, 0, 1)); // 30 rr_ptr=2
    tv.push_back(V(0, 1, 3'b110, 6'b111100, 1, 3'b010, 2'd1, 0, 0, 1)); // 31 wrap, skip HP

    foreach (tv[i]) begin
      @(negedge clk);
      rst_a = tv[i].rst; rdy_a = tv[i].rdy; v_a = tv[i].v; c_a = tv[i].c;
      #1;
      chk("ack_out", i, {7'd0, ao_a}, {7'd0, tv[i].ao});
      chk("ack_req", i, {5'd0, ar_a}, {5'd0, tv[i].ar});
      chk("select", i, {5'd0, sel_a}, {5'd0, tv[i].ar});
      chk("grant_idx", i, {6'd0, gi_a}, {6'd0, tv[i].gi});
      if (tv[i].chk_reg) begin
        chk("busy", i, {7'd0, bz_a}, {7'd0, tv[i].bz});
        chk("err_overrun", i, {7'd0, er_a}, {7'd0, tv[i].er});
      end
    end

    // Round-robin fairness: all four request continuously, 2-flit packets back to back.
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1; rdy_b = 1'b1; v_b = 4'b1111; c_b = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      rst_b = 1'b0;
      c_b   = (cyc % 2 == 1) ? 8'hFF : 8'h00;
      #1;
      chk("rr_ack_out", 100 + cyc, {7'd0, ao_b}, 8'd1);
      chk("rr_ack_req", 100 + cyc, {4'd0, ar_b}, 8'd1 << ((cyc / 2) % 4));
      chk("rr_select", 100 + cyc, {4'd0, sel_b}, 8'd1 << ((cyc / 2) % 4));
      chk("rr_grant_idx", 100 + cyc, {6'd0, gi_b}, 8'((cyc / 2) % 4));
      chk("rr_busy", 100 + cyc, {7'd0, bz_b}, 8'(cyc % 2));
      chk("rr_err", 100 + cyc, {7'd0, er_b}, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
